// File: rtl/cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl
//   Run/stop controller for the CPU core. Debounces the run push-button,
//   gates the core through a clock-enable, reacts to halt requests and,
//   when CPU_RUN_WDOG_EN is defined, to a commit-inactivity watchdog.
//   Also counts retired instructions for the debug LEDs.
//
//   Optional feature macro: CPU_RUN_WDOG_EN (watchdog counter, expiry
//   transition and sticky wdog_flag). Undefined: wdog_flag tied to 0.
//
// Ports
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   btn_run       in   raw asynchronous run button, active-high
//   commit_valid  in   one pulse per retired instruction
//   halt_req      in   core halt request (level or pulse)
//   cpu_en        out  core clock-enable, 1 only in RUN
//   cpu_state     out  display select, 1 = OFF (stopped/halted), 0 = CPU
//   wdog_flag     out  sticky, last halt was caused by the watchdog
//   commit_cnt    out  32-bit retired-instruction count (wraps)
//
// state | meaning
// ------+---------------------------------------------------------------
// STOP  | core gated off, waiting for a button press (reset state)
// RUN   | core enabled, counting commits, watchdog armed
// HALT  | core stopped by halt_req or watchdog, waiting for a press
// ---------------------------------------------------------------------------
module cpu_run_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned WDOG_CYCLES     = 50000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_run,
  input  logic        commit_valid,
  input  logic        halt_req,
  output logic        cpu_en,
  output logic        cpu_state,
  output logic        wdog_flag,
  output logic [31:0] commit_cnt
);

  if (DEBOUNCE_CYCLES < 2 || WDOG_CYCLES < 2) begin : g_param_check
    $error("cpu_run_ctrl: DEBOUNCE_CYCLES and WDOG_CYCLES must be >= 2");
  end

  localparam int unsigned DBC_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic             btn_s1, btn_s2;
  logic             btn_acc;
  logic [DBC_W-1:0] dbc_cnt;
  logic             press;
  logic             run_entry;
  logic             wdog_expire;

  // Button synchronizer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      btn_s1 <= btn_run;
      btn_s2 <= btn_s1;
    end
  end

  // Stable counter. While the synchronized level differs from the accepted
  // level the counter runs; the level returning to the accepted value is the
  // only possible change, and it restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_acc <= 1'b0;
      dbc_cnt <= '0;
      press   <= 1'b0;
    end else begin
      press <= 1'b0;
      if (btn_s2 == btn_acc) begin
        dbc_cnt <= '0;
      end else if (dbc_cnt == DBC_LAST) begin
        btn_acc <= btn_s2;
        dbc_cnt <= '0;
        press   <= btn_s2;
      end else begin
        dbc_cnt <= dbc_cnt + 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_STOP;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next state; halt_req outranks the watchdog, which outranks press
  always_comb begin
    state_nx  = state;
    run_entry = 1'b0;
    case (state)
      ST_STOP: begin
        if (press) begin
          state_nx  = ST_RUN;
          run_entry = 1'b1;
        end
      end
      ST_RUN: begin
        if (halt_req) begin
          state_nx = ST_HALT;
        end else if (wdog_expire) begin
          state_nx = ST_HALT;
        end else if (press) begin
          state_nx = ST_STOP;
        end
      end
      ST_HALT: begin
        if (press) begin
          state_nx = ST_STOP;
        end
      end
      default: state_nx = ST_STOP;
    endcase
  end

  // Outputs registered from the next state so they move with the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_en    <= 1'b0;
      cpu_state <= 1'b1;
    end else begin
      cpu_en    <= (state_nx == ST_RUN);
      cpu_state <= (state_nx != ST_RUN);
    end
  end

  // Retired-instruction counter; commits in the halting cycle still count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_cnt <= '0;
    end else if (run_entry) begin
      commit_cnt <= '0;
    end else if (state == ST_RUN && commit_valid) begin
      commit_cnt <= commit_cnt + 32'd1;
    end
  end

`ifdef CPU_RUN_WDOG_EN
  localparam int unsigned WDOG_W = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] wdog_cnt;

  // Count reaches WDOG_LAST WDOG_CYCLES-1 edges after the last commit, so
  // the transition lands exactly WDOG_CYCLES edges after it.
  assign wdog_expire = (state == ST_RUN) && !commit_valid && (wdog_cnt == WDOG_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt <= '0;
    end else if (run_entry) begin
      wdog_cnt <= '0;
    end else if (state == ST_RUN) begin
      if (commit_valid) begin
        wdog_cnt <= '0;
      end else begin
        wdog_cnt <= wdog_cnt + 1'b1;
      end
    end
  end

  // Sticky until the next STOP->RUN; a simultaneous halt_req wins the cause
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_flag <= 1'b0;
    end else if (run_entry) begin
      wdog_flag <= 1'b0;
    end else if (wdog_expire && !halt_req) begin
      wdog_flag <= 1'b1;
    end
  end
`else
  assign wdog_expire = 1'b0;
  assign wdog_flag   = 1'b0;
`endif

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/stop controller sitting directly upstream of the board status display. It debounces the run push-button, gates the CPU core via a clock-enable, watches for a halt request and (optionally) a commit-inactivity watchdog, and drives the 1-bit `cpu_state` that the display turns into "OFF" (1) or "CPU" (0). It also keeps a retired-instruction counter for the debug LEDs.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: cycles the synchronized button level must stay stable before it is accepted (minimum 2).
- `WDOG_CYCLES`, default 50000000: consecutive no-commit cycles in RUN that trigger a watchdog halt (minimum 2).
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `btn_run`  in  1  raw asynchronous push-button, active-high.
- `commit_valid`  in  1  one pulse per retired instruction from the core.
- `halt_req`  in  1  core halt request (ecall/ebreak), level or pulse.
- `cpu_en`  out  1  core clock-enable; 1 only in RUN.
- `cpu_state`  out  1  display select: 1 = stopped/halted ("OFF"), 0 = running ("CPU").
- `wdog_flag`  out  1  sticky; set when the last halt came from the watchdog.
- `commit_cnt`  out  32  retired-instruction count.

## Operation
- Button path: 2-FF synchronizer -> stable counter. Counter restarts on any change of the synchronized level. The accepted level updates when the counter reaches `DEBOUNCE_CYCLES-1`. `press` is a one-cycle pulse on an accepted 0->1 edge. Releases produce no event.
- FSM states: STOP (reset), RUN, HALT.
  - STOP + press -> RUN. On this transition, `commit_cnt`, the watchdog counter and `wdog_flag` clear.
  - RUN + `halt_req` -> HALT.
  - RUN + watchdog expiry -> HALT, and `wdog_flag` is set.
  - RUN + press -> STOP.
  - HALT + press -> STOP. `wdog_flag` is held.
- Outputs:
  - `cpu_en` = 1 in RUN, else 0.
  - `cpu_state` = 0 in RUN, else 1.
  - Both outputs are registered and decoded from the next state, so they change on the same edge as the state.
- `commit_cnt`: increments on `commit_valid` only while in RUN. It is 32-bit unsigned and wraps 0xFFFFFFFF -> 0. `commit_valid` outside RUN is ignored.
- Watchdog counter:
  - Reloads to 0 on `commit_valid` and on entry to RUN.
  - Otherwise increments in RUN.
  - Expiry occurs when the count equals `WDOG_CYCLES-1` and `commit_valid` is 0.
- Priority inside RUN in one cycle: `halt_req` > watchdog > press.
- `halt_req` in STOP or HALT is ignored.

## Timing
- Reset (async assert, sync release) values:
  - state = STOP
  - `cpu_en` = 0
  - `cpu_state` = 1
  - `wdog_flag` = 0
  - `commit_cnt` = 0
  - debounce and watchdog counters = 0
  - synchronizer and accepted level = 0
- Button latency: 2 synchronizer cycles + `DEBOUNCE_CYCLES` cycles to `press`, then 1 edge to the state and output change.
- `halt_req` sampled at edge N: `cpu_en` = 0 after edge N. A `commit_valid` in that same cycle is still counted.
- Watchdog: with the last commit at edge N, expiry happens at edge N + `WDOG_CYCLES`.
- Reset asserted mid-RUN forces all outputs to reset values immediately, with no clock required.
- Button glitches shorter than `DEBOUNCE_CYCLES` never create a press.

## Configuration
- `CPU_RUN_WDOG_EN` defined: watchdog counter, expiry transition and `wdog_flag` logic are compiled in.
- `CPU_RUN_WDOG_EN` undefined:
  - No watchdog logic; `WDOG_CYCLES` is unused.
  - `wdog_flag` is tied to 0.
  - RUN leaves only on `halt_req` or press.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `WDOG_CYCLES`=16, macro defined unless noted.
- Reset, then hold `btn_run`=1 for 10 cycles -> exactly one press. `cpu_en`: 0 -> 1 and `cpu_state`: 1 -> 0, 7 cycles after the first synchronized sample; `commit_cnt`=0.
- In RUN, 3-cycle button glitch -> no state change. A clean 10-cycle press -> STOP, `cpu_en`=0, `cpu_state`=1.
- In RUN, 5 `commit_valid` pulses, then `halt_req` together with a 6th commit -> `commit_cnt`=6, state HALT, `cpu_state`=1, `wdog_flag`=0.
- In RUN, commits stop -> HALT exactly 16 cycles after the last commit, `wdog_flag`=1. Press -> STOP with `wdog_flag` still 1. Press -> RUN with `wdog_flag`=0.
- Preload `commit_cnt`=0xFFFFFFFE via force, then 3 commits in RUN -> 0xFFFFFFFF, 0, 1.
- Macro undefined: 100 idle cycles in RUN -> stays RUN, `wdog_flag`=0. `rst_n` pulsed low mid-RUN -> `cpu_en`=0 and `cpu_state`=1 before the next clock edge.
